// File: rtl/serial_eq_amisha_pkg.sv
// Shared types and elaboration helpers for the serial equality comparator.
package serial_eq_pkg_amisha;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic int unsigned iw_f(int unsigned width);
    return $clog2(width);
  endfunction

  function automatic bit width_legal(int unsigned width);
    return (width >= 2) && (width <= 64);
  endfunction

endpackage

// File: rtl/serial_eq_amisha_if.sv
// Request/result bundle between a requester and the serial equality comparator.
interface serial_eq_amisha_if #(
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned IW = serial_eq_pkg_amisha::iw_f(WIDTH);

  logic             start_amisha;
  logic [WIDTH-1:0] a_amisha;
  logic [WIDTH-1:0] b_amisha;
  logic             ready_amisha;
  logic             busy_amisha;
  logic             valid_amisha;
  logic             eq_amisha;
  logic [IW-1:0]    mis_idx_amisha;

  modport master (
    output start_amisha,
    output a_amisha,
    output b_amisha,
    input  ready_amisha,
    input  busy_amisha,
    input  valid_amisha,
    input  eq_amisha,
    input  mis_idx_amisha
  );

  modport slave (
    input  start_amisha,
    input  a_amisha,
    input  b_amisha,
    output ready_amisha,
    output busy_amisha,
    output valid_amisha,
    output eq_amisha,
    output mis_idx_amisha
  );

endinterface

// File: rtl/serial_eq_amisha_eq_bit_cell.sv
// Combinational 1-bit equality cell.
module eq_bit_cell_amisha (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o
);

  assign eq_o = (~a_i & ~b_i) | (a_i & b_i);

endmodule

// File: rtl/serial_eq_amisha.sv
// Serial LSB-first word comparator: shifts bit pairs through an equality cell and
// accumulates a word verdict plus the index of the first mismatching bit.
module serial_eq_amisha
  import serial_eq_pkg_amisha::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input logic               clk_amisha,
  input logic               rst_n_amisha,
  serial_eq_amisha_if.slave cmp_io
);

  localparam int unsigned IW = iw_f(WIDTH);
  localparam logic [IW-1:0] CntLast = IW'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("serial_eq_amisha: WIDTH must be in 2..64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic [IW-1:0]    mis_acc_q, mis_acc_d;
  logic             eq_out_q, eq_out_d;
  logic [IW-1:0]    mis_out_q, mis_out_d;
  logic             bit_eq;

  eq_bit_cell_amisha u_cell (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .eq_o (bit_eq)
  );

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    eq_acc_d  = eq_acc_q;
    mis_acc_d = mis_acc_q;
    eq_out_d  = eq_out_q;
    mis_out_d = mis_out_q;
    unique case (state_q)
      StIdle: begin
        if (cmp_io.start_amisha) begin
          sa_d      = cmp_io.a_amisha;
          sb_d      = cmp_io.b_amisha;
          cnt_d     = '0;
          eq_acc_d  = 1'b1;
          mis_acc_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        // Only the first mismatch is recorded.
        if (!bit_eq && eq_acc_q) begin
          eq_acc_d  = 1'b0;
          mis_acc_d = cnt_q;
        end
        if ((cnt_q == CntLast) || (EARLY_EXIT && !bit_eq)) begin
          state_d   = StDone;
          eq_out_d  = eq_acc_d;
          mis_out_d = mis_acc_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      eq_acc_q  <= 1'b1;
      mis_acc_q <= '0;
      eq_out_q  <= 1'b1;
      mis_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      eq_acc_q  <= eq_acc_d;
      mis_acc_q <= mis_acc_d;
      eq_out_q  <= eq_out_d;
      mis_out_q <= mis_out_d;
    end
  end

  assign cmp_io.ready_amisha   = (state_q == StIdle);
  assign cmp_io.busy_amisha    = (state_q == StShift);
  assign cmp_io.valid_amisha   = (state_q == StDone);
  assign cmp_io.eq_amisha      = eq_out_q;
  assign cmp_io.mis_idx_amisha = mis_out_q;

endmodule

// File: doc/serial_eq_amisha.md
# serial_eq_amisha

Serial multi-bit equality comparator. It accepts two WIDTH-bit words through a start/ready handshake, then compares them one bit per clock, LSB first, through a 1-bit equality cell. It reports word equality and the index of the first mismatching bit. It is the sequential stage directly upstream of the per-bit equality logic: it feeds bit pairs into that logic and accumulates the per-bit results into a word-level verdict.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range is 2..64.
- EARLY_EXIT, 0, when 1 the comparison stops at the first mismatching bit.

Ports:
- clk_amisha  in  1  single clock; all state changes on the rising edge.
- rst_n_amisha  in  1  reset, asynchronous, active-low.
- start_amisha  in  1  request to compare; sampled only while ready_amisha=1.
- a_amisha  in  WIDTH  operand A; captured on the accepted start.
- b_amisha  in  WIDTH  operand B; captured on the accepted start.
- ready_amisha  out  1  high in IDLE only.
- busy_amisha  out  1  high in SHIFT only.
- valid_amisha  out  1  one-cycle pulse; the result is complete.
- eq_amisha  out  1  1 when all compared bits matched; held until the next accepted start.
- mis_idx_amisha  out  IW  index of the first mismatching bit, 0 when eq_amisha=1; held like eq_amisha. IW = $clog2(WIDTH).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start_amisha=1, load shift registers sa<=a_amisha and sb<=b_amisha.
  - Set cnt<=0, eq_acc<=1, mis_idx<=0.
  - Move to SHIFT.
- SHIFT, every cycle:
  - bit_eq = the equality-cell output for sa[0] and sb[0].
  - Shift sa and sb right by one.
  - If bit_eq=0 and eq_acc=1, set mis_idx<=cnt and eq_acc<=0. A later mismatch never overwrites mis_idx.
  - If cnt==WIDTH-1, go to DONE; otherwise cnt<=cnt+1.
  - If EARLY_EXIT=1 and bit_eq=0, go to DONE immediately.
- DONE: valid_amisha=1 for this single cycle; eq_amisha and mis_idx_amisha present their final values; next state is IDLE.
- start_amisha is ignored in SHIFT and DONE, with no queuing. Operand changes outside the accept cycle have no effect.
- cnt width is IW and never wraps past WIDTH-1. For WIDTH that is a power of two, the terminal compare is cnt==WIDTH-1, not overflow.
- Reset at any time, including mid-SHIFT, forces IDLE and aborts the comparison. No valid_amisha pulse is produced for the aborted request.

## Timing
- Reset values: ready_amisha=1, busy_amisha=0, valid_amisha=0, eq_amisha=1, mis_idx_amisha=0, cnt=0, sa=sb=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Start accepted at rising edge E0. Full compare: valid_amisha is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles from accept to valid.
- Early exit on bit i: valid_amisha is high after edge E0+i+1.
- Back-to-back throughput: one result per WIDTH+2 cycles. ready_amisha returns the cycle after DONE.
- eq_amisha and mis_idx_amisha update at the SHIFT→DONE edge. They stay stable until the edge following the next accepted start.

## Structure
- Shared package serial_eq_pkg_amisha holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - the localparam function for IW;
  - the parameter legality check (WIDTH 2..64).
- Sub-module eq_bit_cell_amisha is a combinational 1-bit equality cell computing (~a&~b)|(a&b). It is instantiated once on sa[0]/sb[0].
- Top level holds the FSM, counter, shift registers and result registers.

## Test plan
- WIDTH=8, EARLY_EXIT=0: a=0xA5, b=0xA5 -> valid after 9 cycles, eq=1, idx=0; ready returns the cycle after.
- a=0xA5, b=0xA4 -> eq=0, idx=0. a=0x80, b=0x00 -> eq=0, idx=7, valid after 9 cycles.
- a=0x0C, b=0x00, i.e. mismatches at bits 2 and 3 -> idx=2; the later mismatch does not overwrite it.
- EARLY_EXIT=1: a=0x01, b=0x03 -> eq=0, idx=1, valid 3 cycles after accept, busy drops early. Equal words -> full 9-cycle latency.
- start pulsed with new operands during SHIFT and during DONE -> ignored; the result matches the original operands and exactly one valid pulse occurs.
- rst_n asserted at cycle 4 of a SHIFT -> all outputs return to reset values asynchronously, with no valid pulse. A new start after release works normally; an a==b pair then gives eq=1.
